axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares one AXI read master (AR/R) between two requesters: instruction fetch (inst) and data load (mem).
- Sits between custom_cpu's fetch port and load port and the single read port of the memory interconnect.
- At most one transaction is outstanding at a time.
- Ties between requesters are broken round-robin.

Parameters:
ADDR_W, 32, address width of all AR channels
DATA_W, 32, data width of all R channels

Ports:
cpu_clk  in  1  clock; all logic on rising edge
cpu_reset_n  in  1  synchronous active-low reset
inst_araddr  in  ADDR_W  fetch request address
inst_arlen  in  8  fetch burst length minus 1
inst_arvalid  in  1  fetch request valid
inst_arready  out  1  fetch request accepted
inst_rdata  out  DATA_W  fetch read data
inst_rlast  out  1  last beat of fetch burst
inst_rvalid  out  1  fetch data valid
inst_rready  in  1  fetch data ready
mem_araddr  in  ADDR_W  load request address
mem_arlen  in  8  load burst length minus 1
mem_arvalid  in  1  load request valid
mem_arready  out  1  load request accepted
mem_rdata  out  DATA_W  load read data
mem_rlast  out  1  last beat of load burst
mem_rvalid  out  1  load data valid
mem_rready  in  1  load data ready
m_araddr  out  ADDR_W  master AR address
m_arlen  out  8  master AR length
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_arvalid  out  1  master AR valid
m_arready  in  1  master AR ready
m_rdata  in  DATA_W  master R data
m_rlast  in  1  master R last
m_rvalid  in  1  master R valid
m_rready  out  1  master R ready
owner  out  1  current owner: 0=inst, 1=mem; valid when busy
busy  out  1  a transaction is in flight (state != IDLE)
inst_wait_cnt  out  32  see Optional Feature
mem_wait_cnt  out  32  see Optional Feature

Behaviour:
- Reset (cpu_reset_n=0 at a clock edge):
  - state=IDLE; m_arvalid=0; m_araddr=0; m_arlen=0; owner=0.
  - last_grant=MEM, so inst wins the first tie after reset.
  - All arready/rvalid/m_rready outputs are 0.
  - Reset mid-transaction abandons it unconditionally; the slave is reset in the same domain.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Arbitration is combinational.
  - Exactly one requester's arready is high for one cycle when any arvalid is high.
  - Single requester: it is granted.
  - Both requesters: the one not equal to last_grant is granted.
  - On grant: latch araddr/arlen into m_araddr/m_arlen, set owner and last_grant to the winner, set m_arvalid=1, go to ADDR.
  - m_arvalid therefore rises one cycle after the requester handshake.
- ADDR:
  - m_arvalid held high with stable address/len until m_arready=1.
  - On that cycle: m_arvalid<=0, go to DATA.
  - Both requester arready=0.
- DATA:
  - Owner's rdata/rlast/rvalid mirror the m_r* signals combinationally; m_rready = owner's rready.
  - Non-owner's rvalid=0 and its rready is ignored.
  - On m_rvalid & m_rready & m_rlast: go to IDLE.
  - A new grant is possible on the very next cycle, giving 1 dead cycle between transactions.
- m_rvalid arriving in IDLE or ADDR is never acknowledged (m_rready=0).
- Requester arvalid held while not granted is not dropped; it is granted in a later IDLE.
- Back-to-back requests from both requesters strictly alternate; neither can starve.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - inst_wait_cnt and mem_wait_cnt increment each cycle the corresponding arvalid=1 and arready=0.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: both ports are driven constant 0; no counter flops are synthesized.

Decomposition:
- Package arb_pkg holds:
  - state enum (IDLE/ADDR/DATA)
  - owner encoding (OWN_INST=0, OWN_MEM=1)
  - AXI constants (AXSIZE_4B=3'b010, AXBURST_INCR=2'b01)
- Sub-module rr_arb2: 2-way round-robin grant.
  - Inputs: req[1:0], last_grant.
  - Output: one-hot gnt[1:0].
  - Purely combinational.

Test Plan:
- Single fetch: inst_arvalid, araddr=0x1000, arlen=0.
  - Required: inst_arready for 1 cycle; m_arvalid the next cycle with m_araddr=0x1000.
  - After m_arready, one R beat 0xDEADBEEF with rlast is delivered on inst_rdata; mem_rvalid stays 0.
- Simultaneous requests right after reset: inst and mem both valid, continuously reissued.
  - Required: grant order inst, mem, inst, mem; owner toggles.
- Burst with backpressure: mem arlen=3; mem_rready toggled 1,0,1,0.
  - Required: 4 beats delivered; m_rready tracks mem_rready; state returns to IDLE only after the rlast handshake.
- AR stall: m_arready held 0 for 5 cycles.
  - Required: m_arvalid and m_araddr stable for all 5 cycles; no arready to either requester.
  - With ARB_PERF_CNT_EN: a waiting inst_arvalid advances inst_wait_cnt by 7 over the stall.
- Reset mid-DATA: cpu_reset_n=0 during beat 2 of a 4-beat burst.
  - Required: the next cycle has state IDLE, all valids 0, owner=0; the next tie grants inst.
- Stray response: m_rvalid=1 while in IDLE.
  - Required: m_rready=0; inst_rvalid and mem_rvalid remain 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_MEM  = 1'b1;

  localparam logic [2:0] AXSIZE_4B    = 3'b010;
  localparam logic [1:0] AXBURST_INCR = 2'b01;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is granted.
module rr_arb2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // req[0] is OWN_INST, req[1] is OWN_MEM.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == OWN_MEM) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master between instruction fetch and data load, one transaction at a time.
// Define ARB_PERF_CNT_EN to enable the per-requester wait-cycle counters.
module axi_rd_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset_n,
  input  logic [ADDR_W-1:0] inst_araddr,
  input  logic [7:0]        inst_arlen,
  input  logic              inst_arvalid,
  output logic              inst_arready,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_rlast,
  output logic              inst_rvalid,
  input  logic              inst_rready,
  input  logic [ADDR_W-1:0] mem_araddr,
  input  logic [7:0]        mem_arlen,
  input  logic              mem_arvalid,
  output logic              mem_arready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rlast,
  output logic              mem_rvalid,
  input  logic              mem_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              owner,
  output logic              busy,
  output logic [31:0]       inst_wait_cnt,
  output logic [31:0]       mem_wait_cnt
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;

  logic       arb_open;
  logic [1:0] gnt;
  logic       in_data;
  logic       inst_own;
  logic       mem_own;

  // No grant may be offered while reset is asserted, otherwise the handshake would be lost.
  assign arb_open = (state_q == IDLE) && cpu_reset_n;

  rr_arb2 u_rr_arb2 (
    .req        ({mem_arvalid & arb_open, inst_arvalid & arb_open}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d      = gnt[1] ? OWN_MEM : OWN_INST;
          last_grant_d = owner_d;
          araddr_d     = gnt[1] ? mem_araddr : inst_araddr;
          arlen_d      = gnt[1] ? mem_arlen : inst_arlen;
          arvalid_d    = 1'b1;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_MEM;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
    end
  end

  assign in_data  = (state_q == DATA);
  assign inst_own = in_data && (owner_q == OWN_INST);
  assign mem_own  = in_data && (owner_q == OWN_MEM);

  assign inst_arready = gnt[0];
  assign mem_arready  = gnt[1];

  assign inst_rdata  = m_rdata;
  assign inst_rlast  = inst_own && m_rlast;
  assign inst_rvalid = inst_own && m_rvalid;
  assign mem_rdata   = m_rdata;
  assign mem_rlast   = mem_own && m_rlast;
  assign mem_rvalid  = mem_own && m_rvalid;
  assign m_rready    = (inst_own && inst_rready) || (mem_own && mem_rready);

  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = AXSIZE_4B;
  assign m_arburst = AXBURST_INCR;
  assign m_arvalid = arvalid_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] inst_wait_q, inst_wait_d;
  logic [31:0] mem_wait_q, mem_wait_d;

  always_comb begin
    inst_wait_d = inst_wait_q + {31'd0, inst_arvalid & ~inst_arready};
    mem_wait_d  = mem_wait_q + {31'd0, mem_arvalid & ~mem_arready};
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset_n) begin
      inst_wait_q <= '0;
      mem_wait_q  <= '0;
    end else begin
      inst_wait_q <= inst_wait_d;
      mem_wait_q  <= mem_wait_d;
    end
  end

  assign inst_wait_cnt = inst_wait_q;
  assign mem_wait_cnt  = mem_wait_q;
`else
  assign inst_wait_cnt = 32'd0;
  assign mem_wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter; honours ARB_PERF_CNT_EN for the counter checks.
module tb_axi_rd_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset_n;
  logic [31:0] inst_araddr, mem_araddr, m_araddr;
  logic [7:0]  inst_arlen, mem_arlen, m_arlen;
  logic        inst_arvalid, inst_arready, inst_rlast, inst_rvalid, inst_rready;
  logic        mem_arvalid, mem_arready, mem_rlast, mem_rvalid, mem_rready;
  logic [31:0] inst_rdata, mem_rdata, m_rdata;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        owner, busy;
  logic [31:0] inst_wait_cnt, mem_wait_cnt;

  int passed = 0;
  int total  = 0;

  always #5 cpu_clk = ~cpu_clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_reset_n  (cpu_reset_n),
    .inst_araddr  (inst_araddr),
    .inst_arlen   (inst_arlen),
    .inst_arvalid (inst_arvalid),
    .inst_arready (inst_arready),
    .inst_rdata   (inst_rdata),
    .inst_rlast   (inst_rlast),
    .inst_rvalid  (inst_rvalid),
    .inst_rready  (inst_rready),
    .mem_araddr   (mem_araddr),
    .mem_arlen    (mem_arlen),
    .mem_arvalid  (mem_arvalid),
    .mem_arready  (mem_arready),
    .mem_rdata    (mem_rdata),
    .mem_rlast    (mem_rlast),
    .mem_rvalid   (mem_rvalid),
    .mem_rready   (mem_rready),
    .m_araddr     (m_araddr),
    .m_arlen      (m_arlen),
    .m_arsize     (m_arsize),
    .m_arburst    (m_arburst),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_rdata      (m_rdata),
    .m_rlast      (m_rlast),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .owner        (owner),
    .busy         (busy),
    .inst_wait_cnt(inst_wait_cnt),
    .mem_wait_cnt (mem_wait_cnt)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_araddr = '0; inst_arlen = '0; inst_arvalid = 0; inst_rready = 0;
    mem_araddr = '0; mem_arlen = '0; mem_arvalid = 0; mem_rready = 0;
    m_arready = 0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
  endtask

  task automatic do_reset();
    cpu_reset_n = 0;
    clear_inputs();
    cyc();
    cyc();
    cpu_reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    cpu_reset_n = 0;
    @(negedge cpu_clk);
    total++;
    if (busy !== 1'b0 || m_arvalid !== 1'b0 || owner !== 1'b0) begin
      $display("FAIL reset_state: busy=%b m_arvalid=%b owner=%b, want 0 0 0", busy, m_arvalid, owner);
    end else passed++;
    total++;
    if (m_araddr !== 32'd0 || m_arlen !== 8'd0) begin
      $display("FAIL reset_ar: m_araddr=%h m_arlen=%h, want 0 0", m_araddr, m_arlen);
    end else passed++;
    total++;
    if (inst_arready !== 1'b0 || mem_arready !== 1'b0 || m_rready !== 1'b0 ||
        inst_rvalid !== 1'b0 || mem_rvalid !== 1'b0) begin
      $display("FAIL reset_hs: arready=%b%b m_rready=%b rvalid=%b%b, want all 0",
               inst_arready, mem_arready, m_rready, inst_rvalid, mem_rvalid);
    end else passed++;
    total++;
    if (m_arsize !== 3'b010 || m_arburst !== 2'b01) begin
      $display("FAIL ar_consts: m_arsize=%b m_arburst=%b, want 010 01", m_arsize, m_arburst);
    end else passed++;
    cyc();
    cpu_reset_n = 1;
  endtask

  task automatic test_single_fetch();
    inst_arvalid = 1; inst_araddr = 32'h1000; inst_arlen = 8'd0; inst_rready = 1;
    @(negedge cpu_clk);
    total++;
    if (inst_arready !== 1'b1 || mem_arready !== 1'b0 || m_arvalid !== 1'b0) begin
      $display("FAIL fetch_grant: inst_arready=%b mem_arready=%b m_arvalid=%b, want 1 0 0",
               inst_arready, mem_arready, m_arvalid);
    end else passed++;
    cyc();
    inst_arvalid = 0; m_arready = 1;
    @(negedge cpu_clk);
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 || m_arlen !== 8'd0 || inst_arready !== 1'b0) begin
      $display("FAIL fetch_ar: m_arvalid=%b m_araddr=%h m_arlen=%h inst_arready=%b, want 1 1000 0 0",
               m_arvalid, m_araddr, m_arlen, inst_arready);
    end else passed++;
    total++;
    if (busy !== 1'b1 || owner !== 1'b0) begin
      $display("FAIL fetch_owner: busy=%b owner=%b, want 1 0", busy, owner);
    end else passed++;
    cyc();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rlast = 1;
    @(negedge cpu_clk);
    total++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hDEADBEEF || inst_rlast !== 1'b1 ||
        mem_rvalid !== 1'b0 || m_rready !== 1'b1 || m_arvalid !== 1'b0) begin
      $display("FAIL fetch_r: rvalid=%b rdata=%h rlast=%b mem_rvalid=%b m_rready=%b m_arvalid=%b, want 1 deadbeef 1 0 1 0",
               inst_rvalid, inst_rdata, inst_rlast, mem_rvalid, m_rready, m_arvalid);
    end else passed++;
    cyc();
    m_rvalid = 0; m_rlast = 0;
    @(negedge cpu_clk);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL fetch_done: busy=%b, want 0", busy);
    end else passed++;
  endtask

  task automatic test_round_robin();
    logic exp_mem;
    do_reset();
    inst_rready = 1; mem_rready = 1;
    inst_arvalid = 1; inst_araddr = 32'h100;
    mem_arvalid = 1; mem_araddr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp_mem = (i % 2) == 1;
      @(negedge cpu_clk);
      total++;
      if (inst_arready !== ~exp_mem || mem_arready !== exp_mem) begin
        $display("FAIL rr_grant%0d: inst_arready=%b mem_arready=%b, want %b %b",
                 i, inst_arready, mem_arready, ~exp_mem, exp_mem);
      end else passed++;
      cyc();
      m_arready = 1;
      @(negedge cpu_clk);
      total++;
      if (owner !== exp_mem || m_araddr !== (exp_mem ? 32'h200 : 32'h100)) begin
        $display("FAIL rr_owner%0d: owner=%b m_araddr=%h, want %b %h",
                 i, owner, m_araddr, exp_mem, exp_mem ? 32'h200 : 32'h100);
      end else passed++;
      cyc();
      m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = 32'(i);
      @(negedge cpu_clk);
      total++;
      if (inst_rvalid !== ~exp_mem || mem_rvalid !== exp_mem) begin
        $display("FAIL rr_rvalid%0d: inst_rvalid=%b mem_rvalid=%b, want %b %b",
                 i, inst_rvalid, mem_rvalid, ~exp_mem, exp_mem);
      end else passed++;
      cyc();
      m_rvalid = 0; m_rlast = 0;
    end
    inst_arvalid = 0; mem_arvalid = 0;
  endtask

  task automatic test_burst_backpressure();
    int  b = 0;
    logic rr;
    mem_arvalid = 1; mem_araddr = 32'h7000; mem_arlen = 8'd3;
    @(negedge cpu_clk);
    total++;
    if (mem_arready !== 1'b1 || inst_arready !== 1'b0) begin
      $display("FAIL burst_grant: mem_arready=%b inst_arready=%b, want 1 0", mem_arready, inst_arready);
    end else passed++;
    cyc();
    mem_arvalid = 0; m_arready = 1;
    @(negedge cpu_clk);
    total++;
    if (m_arlen !== 8'd3 || m_araddr !== 32'h7000) begin
      $display("FAIL burst_ar: m_arlen=%h m_araddr=%h, want 3 7000", m_arlen, m_araddr);
    end else passed++;
    cyc();
    m_arready = 0;
    for (int c = 0; c < 7; c++) begin
      rr = (c % 2) == 0;
      mem_rready = rr; m_rvalid = 1; m_rdata = 32'hA0 + 32'(b); m_rlast = (b == 3);
      @(negedge cpu_clk);
      total++;
      if (m_rready !== rr || mem_rvalid !== 1'b1 || mem_rdata !== 32'hA0 + 32'(b) ||
          mem_rlast !== (b == 3) || inst_rvalid !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL burst_beat c%0d: m_rready=%b rvalid=%b rdata=%h rlast=%b inst_rvalid=%b busy=%b, want %b 1 %h %b 0 1",
                 c, m_rready, mem_rvalid, mem_rdata, mem_rlast, inst_rvalid, busy,
                 rr, 32'hA0 + 32'(b), b == 3);
      end else passed++;
      cyc();
      if (rr) b++;
    end
    m_rvalid = 0; m_rlast = 0; mem_rready = 0;
    @(negedge cpu_clk);
    total++;
    if (busy !== 1'b0 || b != 4) begin
      $display("FAIL burst_done: busy=%b beats=%0d, want 0 4", busy, b);
    end else passed++;
  endtask

  task automatic test_ar_stall();
    logic [31:0] exp_wait;
`ifdef ARB_PERF_CNT_EN
    exp_wait = 32'd7;
`else
    exp_wait = 32'd0;
`endif
    do_reset();
    mem_arvalid = 1; mem_araddr = 32'h2000; mem_arlen = 8'd0; mem_rready = 1;
    @(negedge cpu_clk);
    total++;
    if (mem_arready !== 1'b1) begin
      $display("FAIL stall_grant: mem_arready=%b, want 1", mem_arready);
    end else passed++;
    cyc();
    mem_arvalid = 0; inst_arvalid = 1; inst_araddr = 32'h3000; inst_rready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge cpu_clk);
      total++;
      if (m_arvalid !== 1'b1 || m_araddr !== 32'h2000 || inst_arready !== 1'b0 ||
          mem_arready !== 1'b0) begin
        $display("FAIL stall_hold%0d: m_arvalid=%b m_araddr=%h arready=%b%b, want 1 2000 0 0",
                 k, m_arvalid, m_araddr, inst_arready, mem_arready);
      end else passed++;
      cyc();
    end
    m_arready = 1;
    cyc();
    m_arready = 0; m_rvalid = 1; m_rlast = 1;
    cyc();
    m_rvalid = 0; m_rlast = 0;
    @(negedge cpu_clk);
    total++;
    if (inst_arready !== 1'b1 || inst_wait_cnt !== exp_wait || mem_wait_cnt !== 32'd0) begin
      $display("FAIL stall_wait: inst_arready=%b inst_wait_cnt=%0d mem_wait_cnt=%0d, want 1 %0d 0",
               inst_arready, inst_wait_cnt, mem_wait_cnt, exp_wait);
    end else passed++;
    cyc();
    inst_arvalid = 0; m_arready = 1;
    cyc();
    m_arready = 0; m_rvalid = 1; m_rlast = 1;
    cyc();
    m_rvalid = 0; m_rlast = 0;
    @(negedge cpu_clk);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL stall_done: busy=%b, want 0", busy);
    end else passed++;
  endtask

  task automatic test_reset_mid_data();
    mem_arvalid = 1; mem_araddr = 32'h4000; mem_arlen = 8'd3; mem_rready = 1;
    cyc();
    mem_arvalid = 0; m_arready = 1;
    cyc();
    m_arready = 0; m_rvalid = 1; m_rlast = 0; m_rdata = 32'h10;
    cyc();
    m_rdata = 32'h11;
    cyc();
    m_rdata = 32'h12;
    @(negedge cpu_clk);
    total++;
    if (owner !== 1'b1 || mem_rvalid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL middata_pre: owner=%b mem_rvalid=%b busy=%b, want 1 1 1", owner, mem_rvalid, busy);
    end else passed++;
    cpu_reset_n = 0;
    cyc();
    @(negedge cpu_clk);
    total++;
    if (busy !== 1'b0 || m_arvalid !== 1'b0 || owner !== 1'b0 || mem_rvalid !== 1'b0 ||
        m_rready !== 1'b0) begin
      $display("FAIL middata_reset: busy=%b m_arvalid=%b owner=%b mem_rvalid=%b m_rready=%b, want 0 0 0 0 0",
               busy, m_arvalid, owner, mem_rvalid, m_rready);
    end else passed++;
    cyc();
    cpu_reset_n = 1; m_rvalid = 0;
    inst_arvalid = 1; inst_araddr = 32'h5000; inst_arlen = 8'd0; inst_rready = 1;
    mem_arvalid = 1; mem_araddr = 32'h6000;
    @(negedge cpu_clk);
    total++;
    if (inst_arready !== 1'b1 || mem_arready !== 1'b0) begin
      $display("FAIL middata_tie: inst_arready=%b mem_arready=%b, want 1 0", inst_arready, mem_arready);
    end else passed++;
    cyc();
    inst_arvalid = 0; mem_arvalid = 0; m_arready = 1;
    @(negedge cpu_clk);
    total++;
    if (m_araddr !== 32'h5000 || owner !== 1'b0) begin
      $display("FAIL middata_ar: m_araddr=%h owner=%b, want 5000 0", m_araddr, owner);
    end else passed++;
    cyc();
    m_arready = 0; m_rvalid = 1; m_rlast = 1;
    cyc();
    m_rvalid = 0; m_rlast = 0;
  endtask

  task automatic test_stray_response();
    m_rvalid = 1; m_rlast = 1; m_rdata = 32'h5555AAAA; inst_rready = 1; mem_rready = 1;
    @(negedge cpu_clk);
    total++;
    if (m_rready !== 1'b0 || inst_rvalid !== 1'b0 || mem_rvalid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL stray: m_rready=%b inst_rvalid=%b mem_rvalid=%b busy=%b, want 0 0 0 0",
               m_rready, inst_rvalid, mem_rvalid, busy);
    end else passed++;
    cyc();
    m_rvalid = 0; m_rlast = 0;
  endtask

  initial begin
    cpu_reset_n = 0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_burst_backpressure();
    test_ar_stall();
    test_reset_mid_data();
    test_stray_response();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
